// File: rtl/sap1_uart_loader.sv
// SAP-1 serial program loader: receives an 8N1 frame (sync, 16 data bytes, checksum),
// writes RAM 0..15 through the manual-load port, then hands the CPU over to execute mode.
module sap1_uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       n_clr,
   input  logic       rx,
   output logic       ch_s2,
   output logic       ch_s4,
   output logic [3:0] a,
   output logic [7:0] d,
   output logic       wr_n,
   output logic       cpu_n_clr,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {HUNT, DATA, CHECK, RUN} ld_state_e;

   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             byte_valid_q, byte_valid_d;
   logic             ferr_q, ferr_d;

   ld_state_e        state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [3:0]       a_q, a_d;
   logic [7:0]       d_q, d_d;
   logic             wr_n_q, wr_n_d;
   logic             err_q, err_d;
   logic             run_q, run_d;
   logic             busy_q, busy_d;

   // UART receiver: edge-triggered start, mid-bit sampling, re-arms at mid-stop
   always_comb begin
      rx_state_d   = rx_state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      byte_valid_d = 1'b0;
      ferr_d       = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d      = '0;
               bit_d      = 3'd0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shreg_d = {rx_sync_q, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d        = '0;
               byte_valid_d = rx_sync_q;
               ferr_d       = !rx_sync_q;
               rx_state_d   = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Loader FSM; acts on the registered receiver pulses
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      a_d     = a_q;
      d_d     = d_q;
      wr_n_d  = 1'b1;
      err_d   = err_q;
      if (ferr_q) begin
         state_d = HUNT;
         err_d   = 1'b1;
      end else if (byte_valid_q) begin
         unique case (state_q)
            HUNT, RUN: begin
               if (shreg_q == SYNC_BYTE) begin
                  state_d = DATA;
                  idx_d   = 4'd0;
                  sum_d   = 8'd0;
                  err_d   = 1'b0;
               end
            end
            DATA: begin
               a_d    = idx_q;
               d_d    = shreg_q;
               wr_n_d = 1'b0;
               sum_d  = sum_q + shreg_q;
               idx_d  = idx_q + 4'd1;
               if (idx_q == 4'd15) state_d = CHECK;
            end
            CHECK: begin
               if (shreg_q == sum_q) begin
                  state_d = RUN;
               end else begin
                  state_d = HUNT;
                  err_d   = 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
      run_d  = (state_d == RUN);
      busy_d = (state_d == DATA) || (state_d == CHECK);
   end

   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         cnt_q        <= '0;
         bit_q        <= 3'd0;
         shreg_q      <= 8'd0;
         byte_valid_q <= 1'b0;
         ferr_q       <= 1'b0;
         state_q      <= HUNT;
         idx_q        <= 4'd0;
         sum_q        <= 8'd0;
         a_q          <= 4'd0;
         d_q          <= 8'd0;
         wr_n_q       <= 1'b1;
         err_q        <= 1'b0;
         run_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_state_q   <= rx_state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         byte_valid_q <= byte_valid_d;
         ferr_q       <= ferr_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         sum_q        <= sum_d;
         a_q          <= a_d;
         d_q          <= d_d;
         wr_n_q       <= wr_n_d;
         err_q        <= err_d;
         run_q        <= run_d;
         busy_q       <= busy_d;
      end
   end

   assign ch_s2     = run_q;
   assign ch_s4     = run_q;
   assign cpu_n_clr = run_q;
   assign done      = run_q;
   assign busy      = busy_q;
   assign a         = a_q;
   assign d         = d_q;
   assign wr_n      = wr_n_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sap1_uart_loader.sv
// Directed bench for sap1_uart_loader: good/bad loads, framing error, glitch, reload, reset.
module tb_sap1_uart_loader;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       n_clr;
   logic       rx;
   logic       ch_s2, ch_s4, wr_n, cpu_n_clr, busy, done, err;
   logic [3:0] a;
   logic [7:0] d;

   int tests = 0;
   int fails = 0;

   int         wr_total = 0;
   logic [3:0] wr_a [0:255];
   logic [7:0] wr_d [0:255];

   sap1_uart_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .n_clr(n_clr), .rx(rx),
      .ch_s2(ch_s2), .ch_s4(ch_s4), .a(a), .d(d), .wr_n(wr_n),
      .cpu_n_clr(cpu_n_clr), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Record every write strobe seen on the RAM port
   always @(negedge clk) begin
      if (!wr_n && wr_total < 256) begin
         wr_a[wr_total] = a;
         wr_d[wr_total] = d;
         wr_total = wr_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk) rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_data(input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(8'(8'h10 + i), 1'b1);
   endtask

   task automatic check_writes(input string tag, input int base, input int n);
      chk({tag, "_count"}, 32'(wr_total - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         chk({tag, "_a"}, 32'(wr_a[base + i]), 32'(i));
         chk({tag, "_d"}, 32'(wr_d[base + i]), 32'(8'h10 + i));
      end
   endtask

   task automatic check_run(input string tag);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_ch_s2"}, 32'(ch_s2), 32'd1);
      chk({tag, "_ch_s4"}, 32'(ch_s4), 32'd1);
      chk({tag, "_cpu_n_clr"}, 32'(cpu_n_clr), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ch_s2"}, 32'(ch_s2), 32'd0);
      chk({tag, "_ch_s4"}, 32'(ch_s4), 32'd0);
      chk({tag, "_a"}, 32'(a), 32'd0);
      chk({tag, "_d"}, 32'(d), 32'd0);
      chk({tag, "_wr_n"}, 32'(wr_n), 32'd1);
      chk({tag, "_cpu_n_clr"}, 32'(cpu_n_clr), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int base;
      rx    = 1'b1;
      n_clr = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      n_clr = 1'b1;
      repeat (CPB) @(negedge clk);

      // Good load: leading junk is ignored in HUNT; checksum of 0x10..0x1F is 0x78
      base = wr_total;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      chk("hunt_junk_busy", 32'(busy), 32'd0);
      chk("hunt_junk_writes", 32'(wr_total - base), 32'd0);
      send_byte(8'hA5, 1'b1);
      chk("sync_busy", 32'(busy), 32'd1);
      send_data(0, 15);
      chk("pre_check_done", 32'(done), 32'd0);
      chk("pre_check_busy", 32'(busy), 32'd1);
      send_byte(8'h78, 1'b1);
      repeat (4) @(negedge clk);
      check_writes("good", base, 16);
      check_run("good");
      chk("good_a_hold", 32'(a), 32'hF);
      chk("good_d_hold", 32'(d), 32'h1F);
      chk("good_wr_n", 32'(wr_n), 32'd1);

      // Reload from RUN drops the CPU back to load mode, then a bad checksum
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      chk("reload_cpu_n_clr", 32'(cpu_n_clr), 32'd0);
      chk("reload_ch_s2", 32'(ch_s2), 32'd0);
      chk("reload_ch_s4", 32'(ch_s4), 32'd0);
      chk("reload_done", 32'(done), 32'd0);
      chk("reload_busy", 32'(busy), 32'd1);
      send_data(0, 15);
      send_byte(8'h77, 1'b1);
      repeat (4) @(negedge clk);
      check_writes("badck", base, 16);
      chk("badck_err", 32'(err), 32'd1);
      chk("badck_done", 32'(done), 32'd0);
      chk("badck_cpu_n_clr", 32'(cpu_n_clr), 32'd0);
      chk("badck_busy", 32'(busy), 32'd0);

      // Good frame after the error: sync clears err
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      chk("resync_err", 32'(err), 32'd0);
      send_data(0, 15);
      send_byte(8'h78, 1'b1);
      repeat (4) @(negedge clk);
      check_writes("recover", base, 16);
      check_run("recover");

      // Framing error on B5: only five writes, back to HUNT
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      send_data(0, 4);
      send_byte(8'h15, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check_writes("ferr", base, 5);
      chk("ferr_err", 32'(err), 32'd1);
      chk("ferr_busy", 32'(busy), 32'd0);
      chk("ferr_done", 32'(done), 32'd0);
      chk("ferr_cpu_n_clr", 32'(cpu_n_clr), 32'd0);
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      send_data(0, 15);
      send_byte(8'h78, 1'b1);
      repeat (4) @(negedge clk);
      check_writes("after_ferr", base, 16);
      check_run("after_ferr");

      // Glitch of 3 clocks inside DATA must not produce a write
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      send_data(0, 1);
      @(negedge clk) rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      chk("glitch_writes", 32'(wr_total - base), 32'd2);
      chk("glitch_busy", 32'(busy), 32'd1);
      chk("glitch_err", 32'(err), 32'd0);
      send_data(2, 15);
      send_byte(8'h78, 1'b1);
      repeat (4) @(negedge clk);
      check_writes("glitch", base, 16);
      check_run("glitch");

      // Reset mid-load, in the middle of a data bit, with no clock edge before checking
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      send_data(0, 6);
      chk("midload_writes", 32'(wr_total - base), 32'd7);
      chk("midload_busy", 32'(busy), 32'd1);
      @(negedge clk) rx = 1'b0;
      repeat (CPB + CPB / 2) @(negedge clk);
      @(posedge clk);
      #2 n_clr = 1'b0;
      #1 check_reset("midrst");
      rx = 1'b1;
      repeat (5) @(negedge clk);
      n_clr = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      base = wr_total;
      send_byte(8'hA5, 1'b1);
      send_data(0, 15);
      send_byte(8'h78, 1'b1);
      repeat (4) @(negedge clk);
      check_writes("fresh", base, 16);
      check_run("fresh");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sap1_uart_loader.md
# sap1_uart_loader

Serial program loader for the SAP-1 computer. It receives a framed 8N1 UART stream, writes 16 bytes into SAP-1 RAM addresses 0–15 through the manual-load inputs (`ch_s2`, `ch_s4`, `a`, `d`), and checks a checksum. On a good checksum it switches the computer to execute mode and releases the CPU clear. It is the writer side of the SAP-1 memory-load interface and replaces hand-set switches.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal values are 4 or more.
- `SYNC_BYTE`, default 8'hA5: byte that starts a load frame.
- `clk` in 1: system clock. Everything is registered on the rising edge.
- `n_clr` in 1: reset. One clock; reset is asynchronous and active-low.
- `rx` in 1: UART serial input. Idle high. Asynchronous to `clk`.
- `ch_s2` out 1: SAP-1 address-mux select. 0 = load, 1 = execute.
- `ch_s4` out 1: SAP-1 RAM mode. 0 = load, 1 = execute.
- `a` out 4: RAM address being written.
- `d` out 8: RAM data being written.
- `wr_n` out 1: active-low write strobe, one cycle wide.
- `cpu_n_clr` out 1: clear to the SAP-1 core. Held low while not in RUN.
- `busy` out 1: high in DATA and CHECK states.
- `done` out 1: high in RUN state.
- `err` out 1: sticky error flag. Cleared when the next sync byte is accepted.

## Operation
- **Receiver**
  - `rx` passes through a 2-flop synchronizer.
  - A start bit is a high-to-low transition on the synchronized `rx`.
  - The start bit is re-checked at `CLKS_PER_BIT/2`. If `rx` is high there, the event is a glitch: discard it and return to idle.
  - 8 data bits are sampled LSB first, one every `CLKS_PER_BIT`, at mid-bit.
  - Stop bit sampled 1: `byte_valid` pulses for one cycle.
  - Stop bit sampled 0: framing error. No `byte_valid`; raise a framing-error pulse instead.
- **Frame format:** `SYNC_BYTE`, then B0..B15, then C. C = (B0+…+B15) mod 256.
- **HUNT**
  - Non-sync bytes are ignored.
  - `SYNC_BYTE` → DATA: index=0, sum=0, `err`=0.
- **DATA**
  - Each byte: `a`←index, `d`←byte, `wr_n`←0 for exactly one cycle, sum←sum+byte (8-bit wrap), index←index+1.
  - The byte with index 15 → CHECK.
  - A byte equal to `SYNC_BYTE` inside DATA is ordinary data, not a resync.
- **CHECK**
  - Byte equals sum → RUN.
  - Otherwise → HUNT with `err`=1.
- **RUN**
  - `ch_s2`=`ch_s4`=`cpu_n_clr`=1.
  - Non-sync bytes are ignored.
  - `SYNC_BYTE` → DATA: `ch_s2`=`ch_s4`=`cpu_n_clr`=0 on the same edge, `err`=0.
- **Framing error** in DATA, CHECK or RUN → HUNT, `err`=1, load-mode outputs. No write is issued for the bad byte. In HUNT a framing error only sets `err`.
- `ch_s2`, `ch_s4` and `cpu_n_clr` are 0 in every state except RUN.

## Timing
- **Reset values:** `ch_s2`=0, `ch_s4`=0, `a`=0, `d`=0, `wr_n`=1, `cpu_n_clr`=0, `busy`=0, `done`=0, `err`=0. State is HUNT and the receiver is idle.
- **Reset mid-frame:** everything above is restored immediately. The partial load is abandoned, and the next load restarts at `a`=0.
- **Receive latency:** `byte_valid` is asserted 2 synchronizer cycles plus about 9.5×`CLKS_PER_BIT` after the start-bit falling edge on `rx`.
- **Write timing**
  - `a`, `d` and `wr_n`=0 all update on the edge after `byte_valid`.
  - `wr_n` returns to 1 on the next edge.
  - `a` and `d` hold their values until the next write.
- **Release timing:** `ch_s2`, `ch_s4`, `cpu_n_clr` and `done` go high together on the edge after the checksum `byte_valid`.
- **Back-to-back frames:** frames with zero idle bits between them are received. The receiver re-arms during the stop bit.

## Test plan
- **Reset:** assert `n_clr`=0 mid-bit → all outputs at reset values within the same cycle, with no clock edge required.
- **Good load** (`CLKS_PER_BIT`=16): send 0x00, 0xFF, 0xA5, then 0x10..0x1F, then 0x78.
  - Exactly 16 `wr_n` pulses, with `a`=0..15 and `d`=0x10..0x1F.
  - Then `ch_s2`=`ch_s4`=`cpu_n_clr`=`done`=1 and `err`=0.
- **Bad checksum:** same frame with C=0x77 → `err`=1, `done`=0, `cpu_n_clr`=0, state HUNT. Then resend the good frame → `err` clears on sync, RUN is reached.
- **Framing error:** stop bit forced to 0 on B5 → 5 writes only (`a`=0..4), `err`=1, HUNT. A following good frame loads correctly from `a`=0.
- **Glitch rejection:** `rx` low for 3 clocks → no `byte_valid`, no state change.
- **Reload from RUN and reset mid-load:**
  - From RUN, send 0xA5 → `cpu_n_clr`=`ch_s2`=`ch_s4`=0 on the next edge.
  - After 7 data bytes pulse `n_clr` → reset values; a fresh frame writes starting at `a`=0.
